// File: rtl/control_pipe_if.sv
// Decode-side request and execute-side control word bundle for control_pipe.
interface control_pipe_if;
  logic       in_valid;
  logic [4:0] opcode;
  logic [4:0] aluop;
  logic [4:0] rd;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       flush;
  logic       md_exc;
  logic       stall;
  logic       ex_valid;
  logic       ex_rwe;
  logic [4:0] ex_dest;
  logic [4:0] ex_aluop;
  logic       ex_sei;
  logic       ex_dmwe;
  logic [1:0] ex_wbsel;
  logic [1:0] ex_pcsel;
  logic       md_start;
  logic       md_op;

  modport master (
    output in_valid, opcode, aluop, rd, rs, rt, flush, md_exc,
    input  stall, ex_valid, ex_rwe, ex_dest, ex_aluop, ex_sei, ex_dmwe,
           ex_wbsel, ex_pcsel, md_start, md_op
  );

  modport slave (
    input  in_valid, opcode, aluop, rd, rs, rt, flush, md_exc,
    output stall, ex_valid, ex_rwe, ex_dest, ex_aluop, ex_sei, ex_dmwe,
           ex_wbsel, ex_pcsel, md_start, md_op
  );
endinterface

// File: rtl/control_pipe.sv
// Hazard-aware decode-to-execute control unit with a multicycle mult/div sequencer.
module control_pipe #(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  control_pipe_if.slave pipe
);
  localparam int unsigned CNTW = $clog2(MD_LATENCY);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MD_LATENCY - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(1);

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;
  localparam logic [4:0] R_ZERO  = 5'd0;
  localparam logic [4:0] R_STAT  = 5'd30;
  localparam logic [4:0] R_LINK  = 5'd31;
  localparam logic [1:0] WB_DMEM = 2'b01;

  typedef enum logic [1:0] {RUN, MD_WAIT, MD_DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [4:0]      md_rd_q, md_rd_d;
  logic            md_op_q, md_op_d;
  logic            md_start_q, md_start_d;
  logic            ex_valid_q, ex_valid_d;
  logic            ex_rwe_q, ex_rwe_d;
  logic [4:0]      ex_dest_q, ex_dest_d;
  logic [4:0]      ex_aluop_q, ex_aluop_d;
  logic            ex_sei_q, ex_sei_d;
  logic            ex_dmwe_q, ex_dmwe_d;
  logic [1:0]      ex_wbsel_q, ex_wbsel_d;
  logic [1:0]      ex_pcsel_q, ex_pcsel_d;
  logic            stall_c;

  logic is_alu, is_md, is_j, is_bne, is_jal, is_jr, is_addi, is_blt;
  logic is_sw, is_lw, is_setx, is_bex;
  logic dec_rwe, dec_sei;
  logic [4:0] dec_dest, dec_aluop;
  logic [1:0] dec_wbsel, dec_pcsel;
  logic src_rs, src_rt, src_rd, hit, hazard;

  assign is_alu  = pipe.opcode == OP_ALU;
  assign is_md   = is_alu && (pipe.aluop == ALU_MUL || pipe.aluop == ALU_DIV);
  assign is_j    = pipe.opcode == OP_J;
  assign is_bne  = pipe.opcode == OP_BNE;
  assign is_jal  = pipe.opcode == OP_JAL;
  assign is_jr   = pipe.opcode == OP_JR;
  assign is_addi = pipe.opcode == OP_ADDI;
  assign is_blt  = pipe.opcode == OP_BLT;
  assign is_sw   = pipe.opcode == OP_SW;
  assign is_lw   = pipe.opcode == OP_LW;
  assign is_setx = pipe.opcode == OP_SETX;
  assign is_bex  = pipe.opcode == OP_BEX;

  // Field decode of the decode-stage instruction
  assign dec_rwe   = (is_alu && !is_md) || is_lw || is_jal || is_addi || is_setx;
  assign dec_dest  = is_jal ? R_LINK : (is_setx ? R_STAT : pipe.rd);
  assign dec_aluop = (is_addi || is_lw || is_sw) ? 5'd0 :
                     (is_bne || is_blt || is_bex) ? 5'd1 : pipe.aluop;
  assign dec_sei   = is_addi || is_lw || is_sw;
  assign dec_wbsel = is_lw ? 2'b01 : (is_jal ? 2'b10 : (is_setx ? 2'b11 : 2'b00));
  assign dec_pcsel = (is_bne || is_blt) ? 2'b01 :
                     (is_j || is_jal || is_bex) ? 2'b10 : (is_jr ? 2'b11 : 2'b00);

  // A load in ex is recognised by its DMEM write-back select
  assign src_rs = !(is_j || is_jal || is_setx || is_bex);
  assign src_rt = is_alu;
  assign src_rd = is_sw || is_bne || is_blt || is_jr;
  assign hit    = (src_rs && pipe.rs == ex_dest_q) || (src_rt && pipe.rt == ex_dest_q) ||
                  (src_rd && pipe.rd == ex_dest_q) || (is_bex && ex_dest_q == R_STAT);
  assign hazard = pipe.in_valid && ex_valid_q && ex_wbsel_q == WB_DMEM &&
                  ex_dest_q != R_ZERO && hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_rd_d    = md_rd_q;
    md_op_d    = md_op_q;
    md_start_d = 1'b0;
    ex_valid_d = 1'b0;
    ex_rwe_d   = 1'b0;
    ex_dest_d  = 5'd0;
    ex_aluop_d = 5'd0;
    ex_sei_d   = 1'b0;
    ex_dmwe_d  = 1'b0;
    ex_wbsel_d = 2'b00;
    ex_pcsel_d = 2'b00;
    stall_c    = 1'b0;
    case (state_q)
      RUN: begin
        if (pipe.flush) begin
          stall_c = 1'b0;
        end else if (hazard) begin
          stall_c = 1'b1;
        end else if (pipe.in_valid) begin
          ex_valid_d = 1'b1;
          ex_rwe_d   = dec_rwe;
          ex_dest_d  = dec_dest;
          ex_aluop_d = dec_aluop;
          ex_sei_d   = dec_sei;
          ex_dmwe_d  = is_sw;
          ex_wbsel_d = dec_wbsel;
          ex_pcsel_d = dec_pcsel;
          if (is_md) begin
            md_start_d = 1'b1;
            md_op_d    = pipe.aluop == ALU_DIV;
            md_rd_d    = pipe.rd;
            cnt_d      = CNT_LOAD;
            state_d    = MD_WAIT;
          end
        end
      end
      MD_WAIT: begin
        // Leave as the counter reaches zero; md_exc is sampled on this edge
        stall_c = 1'b1;
        cnt_d   = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d    = MD_DONE;
          ex_valid_d = 1'b1;
          ex_rwe_d   = 1'b1;
          ex_dest_d  = pipe.md_exc ? R_STAT : md_rd_q;
        end
      end
      MD_DONE: begin
        stall_c = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      md_rd_q    <= 5'd0;
      md_op_q    <= 1'b0;
      md_start_q <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_rwe_q   <= 1'b0;
      ex_dest_q  <= 5'd0;
      ex_aluop_q <= 5'd0;
      ex_sei_q   <= 1'b0;
      ex_dmwe_q  <= 1'b0;
      ex_wbsel_q <= 2'b00;
      ex_pcsel_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_rd_q    <= md_rd_d;
      md_op_q    <= md_op_d;
      md_start_q <= md_start_d;
      ex_valid_q <= ex_valid_d;
      ex_rwe_q   <= ex_rwe_d;
      ex_dest_q  <= ex_dest_d;
      ex_aluop_q <= ex_aluop_d;
      ex_sei_q   <= ex_sei_d;
      ex_dmwe_q  <= ex_dmwe_d;
      ex_wbsel_q <= ex_wbsel_d;
      ex_pcsel_q <= ex_pcsel_d;
    end
  end

  assign pipe.stall    = stall_c;
  assign pipe.ex_valid = ex_valid_q;
  assign pipe.ex_rwe   = ex_rwe_q;
  assign pipe.ex_dest  = ex_dest_q;
  assign pipe.ex_aluop = ex_aluop_q;
  assign pipe.ex_sei   = ex_sei_q;
  assign pipe.ex_dmwe  = ex_dmwe_q;
  assign pipe.ex_wbsel = ex_wbsel_q;
  assign pipe.ex_pcsel = ex_pcsel_q;
  assign pipe.md_start = md_start_q;
  assign pipe.md_op    = md_op_q;
endmodule
